// File: rtl/icache_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | icache_pkg                                                            |
// | Shared types, default geometry and address helpers for i_cache_ctrl.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package icache_pkg;

   localparam int DEF_WIDTH_ADD = 32;
   localparam int DEF_DATA      = 32;
   localparam int DEF_N_WORD    = 8;
   localparam int DEF_N_SETS    = 32;

   localparam int BYTE_OFF_W = 2;
   localparam int WORD_OFF_W = $clog2(DEF_N_WORD);
   localparam int INDEX_W    = $clog2(DEF_N_SETS);
   localparam int TAG_W      = DEF_WIDTH_ADD - INDEX_W - WORD_OFF_W - BYTE_OFF_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      RESP   = 2'd2
   } state_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr,
                                              input int unsigned off_bits);
      return (addr >> off_bits) << off_bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i_cache_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i_cache_ctrl_if                                                       |
// | Fetch-side and refill-side signals of the instruction cache.          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface i_cache_ctrl_if #(
   parameter int WIDTH_ADD = 32,
   parameter int DATA      = 32,
   parameter int N_WORD    = 8
);
   logic [WIDTH_ADD-1:0]   PC_ADDR;
   logic                   PC_REQ;
   logic                   FLUSH;
   logic [DATA-1:0]        INSTR;
   logic                   INSTR_VALID;
   logic                   STALL;
   logic [WIDTH_ADD-1:0]   RD_ADD_MEM;
   logic                   WR_EN_MEM;
   logic [DATA*N_WORD-1:0] Data_RD_MEM;
   logic                   RD_Valid_MEM;
   logic [31:0]            HIT_CNT;
   logic [31:0]            MISS_CNT;

   modport slave (
      input  PC_ADDR, PC_REQ, FLUSH, Data_RD_MEM, RD_Valid_MEM,
      output INSTR, INSTR_VALID, STALL, RD_ADD_MEM, WR_EN_MEM, HIT_CNT, MISS_CNT
   );

   modport master (
      output PC_ADDR, PC_REQ, FLUSH, Data_RD_MEM, RD_Valid_MEM,
      input  INSTR, INSTR_VALID, STALL, RD_ADD_MEM, WR_EN_MEM, HIT_CNT, MISS_CNT
   );
endinterface
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | icache_array                                                          |
// | Valid/tag/data storage: async read, sync write, one-cycle flush.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module icache_array
   import icache_pkg::*;
#(
   parameter int N_SETS = DEF_N_SETS,
   parameter int IDX_W  = INDEX_W,
   parameter int TAG_BW = TAG_W,
   parameter int LINE_W = DEF_DATA * DEF_N_WORD
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_BW-1:0] rd_tag_o,
   output logic [LINE_W-1:0] rd_line_o,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [TAG_BW-1:0] wr_tag_i,
   input  logic [LINE_W-1:0] wr_line_i,
   input  logic              wr_valid_i,
   input  logic              flush_i
);

   logic [N_SETS-1:0] valid_q;
   logic [TAG_BW-1:0] tag_mem [N_SETS];
   logic [LINE_W-1:0] data_mem [N_SETS];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_mem[rd_idx_i];
   assign rd_line_o  = data_mem[rd_idx_i];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (flush_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

   // Contents carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_mem[wr_idx_i]  <= wr_tag_i;
         data_mem[wr_idx_i] <= wr_line_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/i_cache_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i_cache_ctrl                                                          |
// | Direct-mapped I-cache controller: hits from local arrays, misses      |
// | refilled a full line at a time. ICACHE_PERF_CNT_EN builds counters.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module i_cache_ctrl
   import icache_pkg::*;
#(
   parameter int WIDTH_ADD = DEF_WIDTH_ADD,
   parameter int DATA      = DEF_DATA,
   parameter int N_WORD    = DEF_N_WORD,
   parameter int N_SETS    = DEF_N_SETS
) (
   input  logic          AXI_CLK,
   input  logic          AXI_RESETn,
   i_cache_ctrl_if.slave bus
);

   localparam int WOFF_BITS = $clog2(N_WORD);
   localparam int OFF_BITS  = BYTE_OFF_W + WOFF_BITS;
   localparam int IDX_BITS  = $clog2(N_SETS);
   localparam int TAG_BITS  = WIDTH_ADD - IDX_BITS - OFF_BITS;
   localparam int LINE_W    = DATA * N_WORD;

   state_t               state_q, state_d;
   logic [WOFF_BITS-1:0] woff_q, woff_d;
   logic                 flush_seen_q, flush_seen_d;
   logic [DATA-1:0]      instr_q, instr_d;
   logic                 instr_valid_q, instr_valid_d;
   logic                 stall_q, stall_d;
   logic [WIDTH_ADD-1:0] rd_add_q, rd_add_d;
   logic                 wr_en_q, wr_en_d;

   logic [WOFF_BITS-1:0] pc_woff;
   logic [IDX_BITS-1:0]  pc_idx;
   logic [TAG_BITS-1:0]  pc_tag;
   logic                 arr_valid;
   logic [TAG_BITS-1:0]  arr_tag;
   logic [LINE_W-1:0]    arr_line;
   logic                 hit;
   logic                 install;
   logic                 install_valid;
   logic                 unused_byte_off;

   assign pc_woff         = bus.PC_ADDR[BYTE_OFF_W +: WOFF_BITS];
   assign pc_idx          = bus.PC_ADDR[OFF_BITS +: IDX_BITS];
   assign pc_tag          = bus.PC_ADDR[WIDTH_ADD-1 -: TAG_BITS];
   assign unused_byte_off = ^bus.PC_ADDR[BYTE_OFF_W-1:0];

   // A flush seen anywhere in the refill keeps the installed line invalid.
   assign hit           = arr_valid && (arr_tag == pc_tag) && !bus.FLUSH;
   assign install       = (state_q == REFILL) && bus.RD_Valid_MEM;
   assign install_valid = !(bus.FLUSH || flush_seen_q);

   icache_array #(
      .N_SETS (N_SETS),
      .IDX_W  (IDX_BITS),
      .TAG_BW (TAG_BITS),
      .LINE_W (LINE_W)
   ) u_array (
      .clk_i      (AXI_CLK),
      .rst_ni     (AXI_RESETn),
      .rd_idx_i   (pc_idx),
      .rd_valid_o (arr_valid),
      .rd_tag_o   (arr_tag),
      .rd_line_o  (arr_line),
      .we_i       (install),
      .wr_idx_i   (rd_add_q[OFF_BITS +: IDX_BITS]),
      .wr_tag_i   (rd_add_q[WIDTH_ADD-1 -: TAG_BITS]),
      .wr_line_i  (bus.Data_RD_MEM),
      .wr_valid_i (install_valid),
      .flush_i    (bus.FLUSH)
   );

   always_comb begin
      state_d       = state_q;
      woff_d        = woff_q;
      flush_seen_d  = flush_seen_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      stall_d       = stall_q;
      rd_add_d      = rd_add_q;
      wr_en_d       = wr_en_q;
      case (state_q)
         IDLE: begin
            if (bus.PC_REQ) begin
               if (hit) begin
                  instr_d       = arr_line[pc_woff*DATA +: DATA];
                  instr_valid_d = 1'b1;
               end else begin
                  woff_d       = pc_woff;
                  rd_add_d     = WIDTH_ADD'(line_align(32'(bus.PC_ADDR), OFF_BITS));
                  wr_en_d      = 1'b1;
                  stall_d      = 1'b1;
                  flush_seen_d = 1'b0;
                  state_d      = REFILL;
               end
            end
         end
         REFILL: begin
            if (bus.FLUSH) begin
               flush_seen_d = 1'b1;
            end
            if (bus.RD_Valid_MEM) begin
               instr_d = bus.Data_RD_MEM[woff_q*DATA +: DATA];
               wr_en_d = 1'b0;
               state_d = RESP;
            end
         end
         RESP: begin
            instr_valid_d = 1'b1;
            stall_d       = 1'b0;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
      if (!AXI_RESETn) begin
         state_q       <= IDLE;
         woff_q        <= '0;
         flush_seen_q  <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         stall_q       <= 1'b0;
         rd_add_q      <= '0;
         wr_en_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         woff_q        <= woff_d;
         flush_seen_q  <= flush_seen_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         stall_q       <= stall_d;
         rd_add_q      <= rd_add_d;
         wr_en_q       <= wr_en_d;
      end
   end

   assign bus.INSTR       = instr_q;
   assign bus.INSTR_VALID = instr_valid_q;
   assign bus.STALL       = stall_q;
   assign bus.RD_ADD_MEM  = rd_add_q;
   assign bus.WR_EN_MEM   = wr_en_q;

`ifdef ICACHE_PERF_CNT_EN
   logic        hit_evt, miss_evt;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   assign hit_evt  = (state_q == IDLE) && bus.PC_REQ && hit;
   assign miss_evt = (state_q == IDLE) && bus.PC_REQ && !hit;

   // Saturating; FLUSH deliberately leaves the counts alone.
   always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
      if (!AXI_RESETn) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign bus.HIT_CNT  = hit_cnt_q;
   assign bus.MISS_CNT = miss_cnt_q;
`else
   assign bus.HIT_CNT  = '0;
   assign bus.MISS_CNT = '0;
`endif

endmodule
`default_nettype wire

// File: doc/i_cache_ctrl.md
# i_cache_ctrl

Direct-mapped instruction cache controller between the fetch stage and `I_Cache_AXI`. It accepts word fetches from the core and answers hits from local tag/data arrays. On a miss it stalls fetch, issues a line-refill request to the AXI adapter, then installs the returned 8-word line. It is the upstream producer of the adapter's refill request and the consumer of its line data.

## Interface
- `WIDTH_ADD`, 32: address width
- `DATA`, 32: word width
- `N_WORD`, 8: words per line
- `N_SETS`, 32: number of lines (power of 2)

Ports (clock and reset first):
- `AXI_CLK` in 1: single clock for the block.
- `AXI_RESETn` in 1: reset, asynchronous and active-low.
- `PC_ADDR` in WIDTH_ADD: fetch byte address; bits [1:0] are ignored.
- `PC_REQ` in 1: fetch request; sampled only in IDLE.
- `FLUSH` in 1: invalidate all lines.
- `INSTR` out DATA: fetched word.
- `INSTR_VALID` out 1: one-cycle pulse, `INSTR` valid.
- `STALL` out 1: high while a miss is outstanding.
- `RD_ADD_MEM` out WIDTH_ADD: line-aligned refill address.
- `WR_EN_MEM` out 1: refill request level.
- `Data_RD_MEM` in DATA*N_WORD: returned line; word 0 in bits [31:0].
- `RD_Valid_MEM` in 1: line-valid pulse.
- `HIT_CNT` out 32: hit counter; see Configuration.
- `MISS_CNT` out 32: miss counter; see Configuration.

## Operation
- Address split with defaults: byte offset [1:0], word offset [4:2], index [9:5], tag [31:10]. Widths are derived as log2 of the parameters.
- Storage per set: a valid bit, a tag, and DATA*N_WORD of line data.
- Tag, valid and data are read combinationally from `PC_ADDR`.
- States:
  - IDLE: when `PC_REQ` and hit → latch the selected word, pulse `INSTR_VALID` next cycle, stay in IDLE. When `PC_REQ` and miss → latch {tag,index}, go to REFILL.
  - REFILL:
    - `WR_EN_MEM`=1, held until `RD_Valid_MEM` is seen.
    - `RD_ADD_MEM`={tag,index,offset bits=0}.
    - On `RD_Valid_MEM`: write the line and tag, set valid, capture the requested word, go to RESP.
  - RESP: pulse `INSTR_VALID` with the captured word, return to IDLE.
- `STALL` is 1 from the cycle after miss detection through RESP, inclusive.
- `PC_REQ` is ignored outside IDLE. The core holds the fetch while `STALL` is high.
- `RD_Valid_MEM` outside REFILL is ignored. This covers the adapter's possible trailing pulse.
- `FLUSH` clears all valid bits in one cycle, in any state.
  - FLUSH together with `PC_REQ` in IDLE: the request is treated as a miss.
  - FLUSH during REFILL: the refill completes and the word is delivered, but the line is left invalid.
  - FLUSH in the same cycle as `RD_Valid_MEM`: the line is left invalid.
- Reset values: `INSTR`=0, `INSTR_VALID`=0, `STALL`=0, `RD_ADD_MEM`=0, `WR_EN_MEM`=0, state IDLE, all valid bits 0, counters 0. Data and tag arrays are not reset.
- Reset asserted mid-refill: immediate return to IDLE with `WR_EN_MEM` dropped; the partial request is abandoned.

## Timing
- All outputs are registered.
- Hit: `INSTR_VALID` one cycle after the `PC_REQ` sample edge.
- Miss: `WR_EN_MEM` rises one cycle after the sample edge.
- `WR_EN_MEM` falls on the edge after `RD_Valid_MEM`=1. `INSTR_VALID` follows one cycle later, in RESP.
- Miss latency = memory latency L + 2 cycles. L is unbounded; there is no timeout.
- Back-to-back hits: one per cycle.

## Configuration
- `ICACHE_PERF_CNT_EN`:
  - Defined: `HIT_CNT` increments on each IDLE hit and `MISS_CNT` on each miss detection. Both saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by `FLUSH`.
  - Undefined: both outputs are tied to 0 and no counter logic is built.

## Structure
- Package `icache_pkg` holds:
  - state enum {IDLE, REFILL, RESP};
  - offset, index and tag width localparams;
  - the line-aligned address helper.
- Sub-module `icache_array` holds the valid, tag and data storage: async read, sync write port, single-cycle flush.
- The FSM, output registers and counters live in `i_cache_ctrl`.

## Test plan
- Cold miss:
  - Stimulus: reset, then `PC_REQ` with `PC_ADDR`=0x0000_0104; memory returns the line after 3 cycles with word k = 0xA000_0000+k.
  - Response: `RD_ADD_MEM`=0x0000_0100; `INSTR`=0xA000_0001 after 5 cycles; `STALL` falls after RESP.
- Hit:
  - Stimulus: after the cold miss, `PC_REQ` with 0x0000_011C.
  - Response: `INSTR`=0xA000_0007 one cycle later; `WR_EN_MEM` stays 0.
- Conflict miss:
  - Stimulus: fetch 0x0000_0500 (same index, different tag) → refill; then fetch 0x0000_0100.
  - Response: the second fetch misses again.
- Flush:
  - `FLUSH` during REFILL → the word is delivered, but a re-fetch of the same address misses.
  - `FLUSH` together with a hit request → treated as a miss.
- Reset mid-refill:
  - Stimulus: assert `AXI_RESETn`=0 two cycles into REFILL.
  - Response: `WR_EN_MEM`=0 and `STALL`=0 immediately; a later `RD_Valid_MEM` pulse is ignored.
- Perf counters (`ICACHE_PERF_CNT_EN` defined):
  - Stimulus: 3 misses and 5 hits.
  - Response: `HIT_CNT`=5, `MISS_CNT`=3.
  - Undefined build: both counters read 0.
